processor_datapath: RTL and testbench
=====================================

Name: processor_datapath

Overview:
- 8-bit datapath of the processor, directly downstream of the control unit.
- Consumes the control unit's load, increment, select and ALU strobes and holds the architectural registers PC, MAR, IR, A, B and CCR.
- Drives the memory address and write-data buses.
- Returns IR and CCR_Result to the control unit, closing the fetch/decode/execute loop.

Parameters:
- WIDTH, 8, data, address and register width.
- RESET_PC, 8'h00, value loaded into PC at reset.

Ports:
- clock  in  1  system clock, all registers update on rising edge
- reset  in  1  asynchronous, active-low; clears all registers
- IR_Load  in  1  IR <= Bus2
- MAR_Load  in  1  MAR <= Bus2
- PC_Load  in  1  PC <= Bus2
- PC_Inc  in  1  PC <= PC + 1
- A_Load  in  1  A <= Bus2
- B_Load  in  1  B <= Bus2
- ALU_Sel  in  4  ALU operation select
- CCR_Load  in  1  CCR <= ALU flags
- Bus1_Sel  in  2  00 PC, 01 A, 10 B, 11 8'h00
- Bus2_Sel  in  2  00 ALU result, 01 Bus1, 10 from_memory, 11 8'h00
- from_memory  in  WIDTH  read data from memory
- address  out  WIDTH  memory address = MAR
- to_memory  out  WIDTH  memory write data = Bus1
- IR  out  WIDTH  instruction register
- CCR_Result  out  1  branch condition result

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC.
  - MAR, IR, A, B = 0.
  - CCR (NZVC) = 4'b0000.
  - Hence address=0, to_memory=RESET_PC, CCR_Result=0.
  - Reset asserted mid-instruction discards all state immediately. First edge after release behaves as a normal clocked update.
- Bus1 and Bus2 are combinational muxes. Bus2 select 01 passes Bus1, so PC->MAR is one cycle.
- Register updates happen on the rising edge when their load is 1; otherwise the register holds.
- PC priority: PC_Load over PC_Inc. PC_Inc wraps 8'hFF->8'h00.
- Several loads may be active in one cycle; all take the same Bus2 value.
- ALU: X = Bus1, Y = B register, combinational, zero added latency.
  - 0: X+Y. C = carry out. V = signed overflow.
  - 1: X−Y. C = borrow (X<Y unsigned). V = signed overflow.
  - 2: X*Y, low 8 bits. C = 1 if high byte ≠ 0. V = 0.
  - 3: X/Y unsigned. 4: X%Y unsigned. For both, Y=0 gives result 8'hFF, V=1, C=0.
  - 5 AND, 6 OR, 7 XOR: C = V = 0.
  - 8: −X (two's complement). V = 1 only for X=8'h80. C = 1 if X≠0.
  - 9: ~X. C = V = 0.
  - 10-15: pass X. C = V = 0.
  - All ops: N = result[7], Z = (result==0).
- CCR updates only on CCR_Load; result-to-register takes effect only via Bus2_Sel=00 plus a load, in the same cycle.
- CCR_Result is combinational from IR and registered CCR.
  - Only when IR[7:3]==5'b01100, with cond = IR[2:0]:
    - 0 always 1
    - 1 N, 2 Z, 3 V, 4 C
    - 5 !Z, 6 !N, 7 !C
  - Otherwise CCR_Result = 0.
- No internal state machine. Sequencing is owned entirely by the control unit. The datapath must tolerate any strobe combination without X propagation.

Test Plan:
- Reset release, then Bus1_Sel=00, Bus2_Sel=01, MAR_Load -> MAR=0x00. Next cycle PC_Inc -> PC=0x01. Then from_memory=0x10, Bus2_Sel=10, IR_Load -> IR=0x10.
- A=0x7F, B=0x01, Bus1_Sel=01, ALU_Sel=0, Bus2_Sel=00, A_Load, CCR_Load -> A=0x80, NZVC=1010.
- A=0x05, B=0x05, ALU_Sel=1, CCR_Load -> NZVC=0100. Then IR=0x62 -> CCR_Result=1. IR=0x65 -> CCR_Result=0.
- A=0x09, B=0x00, ALU_Sel=3, A_Load, CCR_Load -> A=0xFF, V=1. Same with B=0x04 -> A=0x02. ALU_Sel=4 with A=0x09, B=0x04 -> A=0x01.
- PC=0xFF, PC_Inc -> 0x00. PC_Load and PC_Inc together with from_memory=0x40, Bus2_Sel=10 -> PC=0x40.
- Load A=0x33, B=0x44, then assert reset low between clock edges -> all registers 0 immediately, CCR_Result=0. Bus1_Sel=10 -> to_memory=0x00.

Source files
------------

// File: rtl/processor_datapath_if.sv
// rtl/processor_datapath_if.sv - control-unit/memory side bundle of the 8-bit datapath
interface processor_datapath_if #(
    parameter int WIDTH = 8
);
    logic             IR_Load;
    logic             MAR_Load;
    logic             PC_Load;
    logic             PC_Inc;
    logic             A_Load;
    logic             B_Load;
    logic [3:0]       ALU_Sel;
    logic             CCR_Load;
    logic [1:0]       Bus1_Sel;
    logic [1:0]       Bus2_Sel;
    logic [WIDTH-1:0] from_memory;
    logic [WIDTH-1:0] address;
    logic [WIDTH-1:0] to_memory;
    logic [WIDTH-1:0] IR;
    logic             CCR_Result;

    modport master (
        output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
        output ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, from_memory,
        input  address, to_memory, IR, CCR_Result
    );

    modport slave (
        input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
        input  ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, from_memory,
        output address, to_memory, IR, CCR_Result
    );
endinterface

// File: rtl/processor_datapath.sv
// rtl/processor_datapath.sv - register file, buses, ALU and branch condition of the processor
module processor_datapath #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = 8'h00
) (
    input  logic               clock,
    input  logic               reset,
    processor_datapath_if.slave dp
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0]   pc, mar, ir, a, b;
    logic [3:0]         ccr;          // {N, Z, V, C}
    logic [WIDTH-1:0]   bus1, bus2, alu_result;
    logic [3:0]         alu_flags;
    logic [WIDTH:0]     alu_sum;
    logic [2*WIDTH-1:0] alu_prod;
    logic               alu_v, alu_c;
    logic               cond_result;

    always_comb begin
        case (dp.Bus1_Sel)
            2'b00:   bus1 = pc;
            2'b01:   bus1 = a;
            2'b10:   bus1 = b;
            default: bus1 = '0;
        endcase
    end

    // X is Bus1 and Y is always the B register.
    always_comb begin
        alu_result = bus1;
        alu_sum    = '0;
        alu_prod   = '0;
        alu_v      = 1'b0;
        alu_c      = 1'b0;
        case (dp.ALU_Sel)
            4'd0: begin
                alu_sum    = {1'b0, bus1} + {1'b0, b};
                alu_result = alu_sum[MSB:0];
                alu_c      = alu_sum[WIDTH];
                alu_v      = (bus1[MSB] == b[MSB]) && (alu_result[MSB] != bus1[MSB]);
            end
            4'd1: begin
                alu_sum    = {1'b0, bus1} - {1'b0, b};
                alu_result = alu_sum[MSB:0];
                alu_c      = alu_sum[WIDTH];
                alu_v      = (bus1[MSB] != b[MSB]) && (alu_result[MSB] != bus1[MSB]);
            end
            4'd2: begin
                alu_prod   = {{WIDTH{1'b0}}, bus1} * {{WIDTH{1'b0}}, b};
                alu_result = alu_prod[MSB:0];
                alu_c      = |alu_prod[2*WIDTH-1:WIDTH];
            end
            4'd3, 4'd4: begin
                if (b == '0) begin
                    alu_result = '1;
                    alu_v      = 1'b1;
                end else if (dp.ALU_Sel == 4'd3) begin
                    alu_result = bus1 / b;
                end else begin
                    alu_result = bus1 % b;
                end
            end
            4'd5: alu_result = bus1 & b;
            4'd6: alu_result = bus1 | b;
            4'd7: alu_result = bus1 ^ b;
            4'd8: begin
                alu_result = -bus1;
                alu_v      = (bus1 == {1'b1, {(WIDTH-1){1'b0}}});
                alu_c      = |bus1;
            end
            4'd9:    alu_result = ~bus1;
            default: alu_result = bus1;
        endcase
        alu_flags = {alu_result[MSB], (alu_result == '0), alu_v, alu_c};
    end

    always_comb begin
        case (dp.Bus2_Sel)
            2'b00:   bus2 = alu_result;
            2'b01:   bus2 = bus1;
            2'b10:   bus2 = dp.from_memory;
            default: bus2 = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc  <= RESET_PC;
            mar <= '0;
            ir  <= '0;
            a   <= '0;
            b   <= '0;
            ccr <= 4'b0000;
        end else begin
            if (dp.PC_Load)       pc  <= bus2;
            else if (dp.PC_Inc)   pc  <= pc + 1'b1;
            if (dp.MAR_Load)      mar <= bus2;
            if (dp.IR_Load)       ir  <= bus2;
            if (dp.A_Load)        a   <= bus2;
            if (dp.B_Load)        b   <= bus2;
            if (dp.CCR_Load)      ccr <= alu_flags;
        end
    end

    // Only the branch opcode group 01100xxx produces a condition; cond lives in IR[2:0].
    always_comb begin
        cond_result = 1'b0;
        if (ir[MSB -: 5] == 5'b01100) begin
            case (ir[2:0])
                3'd0: cond_result = 1'b1;
                3'd1: cond_result = ccr[3];
                3'd2: cond_result = ccr[2];
                3'd3: cond_result = ccr[1];
                3'd4: cond_result = ccr[0];
                3'd5: cond_result = !ccr[2];
                3'd6: cond_result = !ccr[3];
                default: cond_result = !ccr[0];
            endcase
        end
    end

    assign dp.address    = mar;
    assign dp.to_memory  = bus1;
    assign dp.IR         = ir;
    assign dp.CCR_Result = cond_result;
endmodule

// File: tb/tb_processor_datapath.sv
// tb/tb_processor_datapath.sv - scoreboard bench for processor_datapath against an arithmetic model
module tb_processor_datapath;
    localparam int W = 8;

    logic clock = 1'b1;
    logic reset;
    always #5 clock = ~clock;

    processor_datapath_if #(.WIDTH(W)) dp ();

    processor_datapath #(.WIDTH(W), .RESET_PC(8'h00)) dut (
        .clock (clock),
        .reset (reset),
        .dp    (dp)
    );

    typedef struct {
        logic [W-1:0] address;
        logic [W-1:0] to_memory;
        logic [W-1:0] ir;
        logic         ccr_result;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    int m_pc, m_mar, m_ir, m_a, m_b;
    bit m_n, m_z, m_v, m_c;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    task automatic alu_model(input int x, input int y, input int sel,
                             output int r, output bit n, output bit z, output bit v, output bit c);
        int t;
        v = 0;
        c = 0;
        case (sel)
            0: begin
                t = x + y; r = t % 256; c = (t > 255);
                t = to_signed(x) + to_signed(y); v = (t > 127) || (t < -128);
            end
            1: begin
                r = (x - y + 256) % 256; c = (x < y);
                t = to_signed(x) - to_signed(y); v = (t > 127) || (t < -128);
            end
            2: begin t = x * y; r = t % 256; c = (t > 255); end
            3: if (y == 0) begin r = 255; v = 1; end else r = x / y;
            4: if (y == 0) begin r = 255; v = 1; end else r = x % y;
            5: r = x & y;
            6: r = x | y;
            7: r = x ^ y;
            8: begin r = (256 - x) % 256; v = (x == 128); c = (x != 0); end
            9: r = 255 - x;
            default: r = x;
        endcase
        n = (r >= 128);
        z = (r == 0);
    endtask

    function automatic bit cond_model();
        if ((m_ir >> 3) != 12) return 1'b0;
        case (m_ir % 8)
            0: return 1'b1;
            1: return m_n;
            2: return m_z;
            3: return m_v;
            4: return m_c;
            5: return !m_z;
            6: return !m_n;
            default: return !m_c;
        endcase
    endfunction

    // Predict the outputs visible before the next edge, queue them, then advance the model across the edge.
    task automatic cycle();
        exp_t e;
        int   b1, b2, r;
        bit   n, z, v, c;
        if (!reset) begin
            m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0;
            m_n = 0; m_z = 0; m_v = 0; m_c = 0;
        end
        case (int'(dp.Bus1_Sel))
            0: b1 = m_pc;
            1: b1 = m_a;
            2: b1 = m_b;
            default: b1 = 0;
        endcase
        alu_model(b1, m_b, int'(dp.ALU_Sel), r, n, z, v, c);
        e.address    = m_mar[W-1:0];
        e.to_memory  = b1[W-1:0];
        e.ir         = m_ir[W-1:0];
        e.ccr_result = cond_model();
        sb.push_back(e);
        case (int'(dp.Bus2_Sel))
            0: b2 = r;
            1: b2 = b1;
            2: b2 = int'(dp.from_memory);
            default: b2 = 0;
        endcase
        if (reset) begin
            if (dp.IR_Load)  m_ir  = b2;
            if (dp.MAR_Load) m_mar = b2;
            if (dp.A_Load)   m_a   = b2;
            if (dp.B_Load)   m_b   = b2;
            if (dp.PC_Load)     m_pc = b2;
            else if (dp.PC_Inc) m_pc = (m_pc + 1) % 256;
            if (dp.CCR_Load) begin m_n = n; m_z = z; m_v = v; m_c = c; end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        dp.IR_Load = 0; dp.MAR_Load = 0; dp.PC_Load = 0; dp.PC_Inc = 0;
        dp.A_Load = 0; dp.B_Load = 0; dp.CCR_Load = 0;
        dp.ALU_Sel = 4'd0; dp.Bus1_Sel = 2'b00; dp.Bus2_Sel = 2'b00;
    endtask

    task automatic load_mem(input int which, input logic [W-1:0] val);
        idle();
        dp.from_memory = val;
        dp.Bus2_Sel    = 2'b10;
        case (which)
            0: dp.A_Load  = 1;
            1: dp.B_Load  = 1;
            2: dp.IR_Load = 1;
            default: dp.PC_Load = 1;
        endcase
        cycle();
        idle();
    endtask

    task automatic alu_op(input logic [3:0] sel);
        idle();
        dp.Bus1_Sel = 2'b01; dp.ALU_Sel = sel; dp.Bus2_Sel = 2'b00;
        dp.A_Load = 1; dp.CCR_Load = 1;
        cycle();
        idle();
    endtask

    task automatic view_a(input string name, input logic [W-1:0] exp);
        dp.Bus1_Sel = 2'b01;
        #1;
        chk(name, dp.to_memory, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_address", dp.address, e.address);
                chk("sb_to_memory", dp.to_memory, e.to_memory);
                chk("sb_ir", dp.IR, e.ir);
                chk("sb_ccr_result", {7'd0, dp.CCR_Result}, {7'd0, e.ccr_result});
            end
        end
    end

    initial begin : driver
        reset = 0;
        dp.from_memory = '0;
        idle();
        #1;
        chk("reset_address", dp.address, 8'h00);
        chk("reset_to_memory", dp.to_memory, 8'h00);
        chk("reset_ccr_result", {7'd0, dp.CCR_Result}, 8'h00);
        cycle();
        cycle();
        reset = 1;

        dp.Bus1_Sel = 2'b00; dp.Bus2_Sel = 2'b01; dp.MAR_Load = 1;
        cycle();
        idle(); dp.PC_Inc = 1;
        cycle();
        load_mem(2, 8'h10);
        #1;
        chk("fetch_ir", dp.IR, 8'h10);
        chk("fetch_mar", dp.address, 8'h00);
        chk("fetch_pc", dp.to_memory, 8'h01);

        load_mem(0, 8'h7F); load_mem(1, 8'h01);
        alu_op(4'd0);
        view_a("add_overflow", 8'h80);
        load_mem(2, 8'h63); #1; chk("add_v_flag", {7'd0, dp.CCR_Result}, 8'h01);

        load_mem(0, 8'h05); load_mem(1, 8'h05);
        alu_op(4'd1);
        load_mem(2, 8'h62); #1; chk("sub_z_true", {7'd0, dp.CCR_Result}, 8'h01);
        load_mem(2, 8'h65); #1; chk("sub_notz_false", {7'd0, dp.CCR_Result}, 8'h00);

        load_mem(0, 8'h09); load_mem(1, 8'h00);
        alu_op(4'd3);
        view_a("div_by_zero", 8'hFF);
        load_mem(2, 8'h63); #1; chk("div0_v_flag", {7'd0, dp.CCR_Result}, 8'h01);
        load_mem(0, 8'h09); load_mem(1, 8'h04);
        alu_op(4'd3);
        view_a("div", 8'h02);
        load_mem(0, 8'h09);
        alu_op(4'd4);
        view_a("mod", 8'h01);

        load_mem(3, 8'hFF);
        dp.PC_Inc = 1;
        cycle();
        idle(); #1;
        chk("pc_wrap", dp.to_memory, 8'h00);
        dp.from_memory = 8'h40; dp.Bus2_Sel = 2'b10; dp.PC_Load = 1; dp.PC_Inc = 1;
        cycle();
        idle(); #1;
        chk("pc_load_priority", dp.to_memory, 8'h40);

        load_mem(0, 8'h33); load_mem(1, 8'h44);
        reset = 0;
        #1;
        chk("async_reset_address", dp.address, 8'h00);
        chk("async_reset_ccr_result", {7'd0, dp.CCR_Result}, 8'h00);
        dp.Bus1_Sel = 2'b10;
        #1;
        chk("async_reset_b", dp.to_memory, 8'h00);
        cycle();
        reset = 1;

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) != 0);
            dp.IR_Load  = ($urandom_range(0, 3) == 0);
            dp.MAR_Load = ($urandom_range(0, 3) == 0);
            dp.PC_Load  = ($urandom_range(0, 5) == 0);
            dp.PC_Inc   = ($urandom_range(0, 2) == 0);
            dp.A_Load   = ($urandom_range(0, 2) == 0);
            dp.B_Load   = ($urandom_range(0, 2) == 0);
            dp.CCR_Load = ($urandom_range(0, 1) == 0);
            dp.ALU_Sel  = 4'($urandom_range(0, 15));
            dp.Bus1_Sel = 2'($urandom_range(0, 3));
            dp.Bus2_Sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0)
                dp.from_memory = 8'h60 | 8'($urandom_range(0, 7));
            else
                dp.from_memory = 8'($urandom);
            cycle();
        end

        reset = 1;
        idle();
        cycle();
        @(negedge clock);
        @(negedge clock);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
